vga_scan: RTL

VGA_SCAN -- requirements
Module: vga_scan

---
 rtl/vga_scan.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vga_scan.sv
// VGA raster timing generator: free-running h/v scan counters, frame strobe and
// animation counter, and a compositor whose output is delayed to line up with the layers.
module vga_scan #(
  parameter int H_ACTIVE = 1440,
  parameter int H_FP     = 80,
  parameter int H_SYNC   = 152,
  parameter int H_BP     = 232,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 25,
  parameter int H_POL    = 0,
  parameter int V_POL    = 1,
  parameter int LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] pos_x,
  output logic [10:0] pos_y,
  output logic        frameclk,
  output logic [5:0]  count,
  input  logic        isbird,
  input  logic [3:0]  birdr,
  input  logic [3:0]  birdg,
  input  logic [3:0]  birdb,
  input  logic [3:0]  bg_r,
  input  logic [3:0]  bg_g,
  input  logic [3:0]  bg_b,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        HP      = 1'(H_POL);
  localparam logic        VP      = 1'(V_POL);

  logic [10:0] r_h, r_v;
  logic [10:0] w_h_next, w_v_next;
  logic        w_h_last, w_v_last;
  logic        r_frameclk;
  logic [5:0]  r_count;
  logic [2:0]  w_raw, w_tap;
  logic        r_hsync, r_vsync;
  logic [11:0] r_rgb;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_h_next = w_h_last ? 11'd0 : r_h + 11'd1;
  assign w_v_next = w_h_last ? (w_v_last ? 11'd0 : r_v + 11'd1) : r_v;

  // frameclk looks at the next line number so it rises on the very edge the scan enters blanking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h        <= '0;
      r_v        <= '0;
      r_frameclk <= 1'b0;
      r_count    <= '0;
    end else begin
      r_h        <= w_h_next;
      r_v        <= w_v_next;
      r_frameclk <= (w_v_next >= V_ACT);
      if (w_h_last && w_v_last)
        r_count <= (r_count == 6'd59) ? 6'd0 : r_count + 6'd1;
    end
  end

  assign w_raw = {(r_h < H_ACT) && (r_v < V_ACT),
                  (r_h >= HS_BEG) && (r_h < HS_END),
                  (r_v >= VS_BEG) && (r_v < VS_END)};

  // LAT-1 delay stages here; the output register below supplies the last one
  generate
    if (LAT <= 1) begin : g_direct
      assign w_tap = w_raw;
    end else begin : g_delay
      logic [2:0] r_sr [LAT-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT - 1; i++) r_sr[i] <= '0;
        end else begin
          r_sr[0] <= w_raw;
          for (int i = 1; i < LAT - 1; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_tap = r_sr[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~HP;
      r_vsync <= ~VP;
      r_rgb   <= '0;
    end else begin
      r_hsync <= w_tap[1] ~^ HP;
      r_vsync <= w_tap[0] ~^ VP;
      if (!w_tap[2])
        r_rgb <= '0;
      else if (isbird)
        r_rgb <= {birdr, birdg, birdb};
      else
        r_rgb <= {bg_r, bg_g, bg_b};
    end
  end

  assign pos_x    = r_h;
  assign pos_y    = r_v;
  assign frameclk = r_frameclk;
  assign count    = r_count;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign vga_r    = r_rgb[11:8];
  assign vga_g    = r_rgb[7:4];
  assign vga_b    = r_rgb[3:0];

endmodule
